// File: rtl/micro_op_queue_pkg.sv
// Shared decoder types for the micro-op queue: micro-op format, bundle
// count type, queue geometry and the stored entry layout.
package micro_op_queue_pkg;

  typedef struct packed {
    logic [6:0]  opcode;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [11:0] imm;
  } micro_op_t;

  // Must match the cracking function's maximum bundle size.
  localparam int MAX_MOP_CNT = 6;
  localparam int MOPQ_DEPTH  = 16;
  localparam int MOP_W       = $bits(micro_op_t);
  localparam int PTR_W       = $clog2(MOPQ_DEPTH);
  localparam int OCC_W       = PTR_W + 1;

  typedef logic [2:0] mop_cnt_t;

  typedef struct packed {
    micro_op_t mop;
    logic      last;
  } mopq_entry_t;

endpackage

// File: rtl/micro_op_queue_if.sv
// Decode-side bundle push and dispatch-side single-mop pop handshakes.
interface micro_op_queue_if;
  import micro_op_queue_pkg::*;

  logic                         in_valid;
  logic                         in_ready;
  mop_cnt_t                     in_cnt;
  logic [MOP_W*MAX_MOP_CNT-1:0] in_mops;
  logic                         out_valid;
  logic                         out_ready;
  logic [MOP_W-1:0]             out_mop;
  logic                         out_last;

  // Decoder/dispatch side.
  modport master (
    output in_valid, in_cnt, in_mops, out_ready,
    input  in_ready, out_valid, out_mop, out_last
  );

  // Queue side.
  modport slave (
    input  in_valid, in_cnt, in_mops, out_ready,
    output in_ready, out_valid, out_mop, out_last
  );
endinterface

// File: rtl/micro_op_queue_ram.sv
// DEPTH-entry register file: MAX_MOP_CNT write lanes per cycle, one async
// read port. Only the last tags are reset; payload bits are don't-care
// until written.
module micro_op_queue_ram
  import micro_op_queue_pkg::*;
(
  input  logic                                  clk,
  input  logic                                  reset_n,
  input  logic [MAX_MOP_CNT-1:0]                wr_en,
  input  logic [MAX_MOP_CNT-1:0][PTR_W-1:0]     wr_addr,
  input  mopq_entry_t [MAX_MOP_CNT-1:0]         wr_data,
  input  logic [PTR_W-1:0]                      rd_addr,
  output mopq_entry_t                           rd_data
);

  micro_op_t [MOPQ_DEPTH-1:0] mop_q, mop_d;
  logic      [MOPQ_DEPTH-1:0] last_q, last_d;

  // Merge the enabled lanes into the next array image; lanes never collide.
  always_comb begin
    mop_d  = mop_q;
    last_d = last_q;
    for (int i = 0; i < MAX_MOP_CNT; i++) begin
      if (wr_en[i]) begin
        mop_d[wr_addr[i]]  = wr_data[i].mop;
        last_d[wr_addr[i]] = wr_data[i].last;
      end
    end
  end

  // Payload storage, no reset.
  always_ff @(posedge clk) begin
    mop_q <= mop_d;
  end

  // Last tags, cleared on reset.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) last_q <= '0;
    else          last_q <= last_d;
  end

  assign rd_data.mop  = mop_q[rd_addr];
  assign rd_data.last = last_q[rd_addr];

endmodule

// File: rtl/micro_op_queue.sv
// Micro-op queue between decode and dispatch. Accepts a whole bundle only
// when it is guaranteed to fit, issues one mop per cycle from the head,
// and clears on flush (branch redirect).
module micro_op_queue
  import micro_op_queue_pkg::*;
(
  input  logic             clk,
  input  logic             reset_n,
  input  logic             flush,
  micro_op_queue_if.slave  bus,
  output logic [OCC_W-1:0] occupancy,
  output logic             err_cnt
);

  logic [PTR_W-1:0] head_q, head_d, tail_q, tail_d;
  logic [OCC_W-1:0] occ_q, occ_d;
  logic             err_q, err_d;
  logic             push, push_ok, pop;

  logic [MAX_MOP_CNT-1:0]            wr_en;
  logic [MAX_MOP_CNT-1:0][PTR_W-1:0] wr_addr;
  mopq_entry_t [MAX_MOP_CNT-1:0]     wr_data;
  mopq_entry_t                       rd_data;

  // Ready only with room for a worst-case bundle; held low in reset/flush.
  assign bus.in_ready  = reset_n && !flush &&
                         (occ_q <= OCC_W'(MOPQ_DEPTH - MAX_MOP_CNT));
  assign bus.out_valid = (occ_q != '0);
  assign push          = bus.in_valid && bus.in_ready;
  assign push_ok       = push && (bus.in_cnt <= mop_cnt_t'(MAX_MOP_CNT));
  assign pop           = bus.out_valid && bus.out_ready && !flush;

  // Unpack the bundle (mop 0 in the MSBs) onto consecutive slots from tail.
  always_comb begin
    for (int i = 0; i < MAX_MOP_CNT; i++) begin
      wr_en[i]        = push_ok && (mop_cnt_t'(i) < bus.in_cnt);
      wr_addr[i]      = tail_q + PTR_W'(i);
      wr_data[i].mop  = bus.in_mops[(MAX_MOP_CNT-1-i)*MOP_W +: MOP_W];
      wr_data[i].last = (mop_cnt_t'(i + 1) == bus.in_cnt);
    end
  end

  // Pointer, occupancy and error-pulse next state; flush overrides all.
  always_comb begin
    head_d = head_q;
    tail_d = tail_q;
    occ_d  = occ_q;
    err_d  = 1'b0;
    if (flush) begin
      head_d = '0;
      tail_d = '0;
      occ_d  = '0;
    end else begin
      if (push_ok) tail_d = tail_q + PTR_W'(bus.in_cnt);
      if (pop)     head_d = head_q + PTR_W'(1);
      occ_d = occ_q + (push_ok ? OCC_W'(bus.in_cnt) : OCC_W'(0))
                    - (pop ? OCC_W'(1) : OCC_W'(0));
      err_d = push && !push_ok;
    end
  end

  // Control state registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      head_q <= '0;
      tail_q <= '0;
      occ_q  <= '0;
      err_q  <= 1'b0;
    end else begin
      head_q <= head_d;
      tail_q <= tail_d;
      occ_q  <= occ_d;
      err_q  <= err_d;
    end
  end

  micro_op_queue_ram u_ram (
    .clk     (clk),
    .reset_n (reset_n),
    .wr_en   (wr_en),
    .wr_addr (wr_addr),
    .wr_data (wr_data),
    .rd_addr (head_q),
    .rd_data (rd_data)
  );

  // Head outputs forced to zero when empty so stale slots never leak.
  assign bus.out_mop  = bus.out_valid ? rd_data.mop  : '0;
  assign bus.out_last = bus.out_valid ? rd_data.last : 1'b0;
  assign occupancy    = occ_q;
  assign err_cnt      = err_q;

endmodule

// File: tb/tb_micro_op_queue.sv
// Bench for micro_op_queue: directed scenarios plus a random run, all
// checked against a queue-of-entries reference model.
module tb_micro_op_queue;
  import micro_op_queue_pkg::*;

  logic             clk = 1'b0;
  logic             reset_n = 1'b0;
  logic             flush = 1'b0;
  logic [OCC_W-1:0] occupancy;
  logic             err_cnt;

  micro_op_queue_if bus();

  micro_op_queue dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .flush     (flush),
    .bus       (bus.slave),
    .occupancy (occupancy),
    .err_cnt   (err_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [MOP_W-1:0] mop;
    logic             last;
  } ent_t;

  ent_t             q[$];
  logic             m_err = 1'b0;
  logic [MOP_W-1:0] bundle[MAX_MOP_CNT];
  int               errors = 0;
  int               checks = 0;

  function automatic logic [MOP_W-1:0] rnd_mop();
    logic [63:0] t;
    t = {$urandom(), $urandom()};
    return t[MOP_W-1:0];
  endfunction

  // Drive one cycle at the falling edge, advance the model at the rising
  // edge, and return 1 ns later so outputs can be sampled.
  task automatic cycle(input logic v, input int c, input logic r, input logic f);
    bit   acc;
    ent_t d;
    @(negedge clk);
    bus.in_valid  = v;
    bus.in_cnt    = 3'(c);
    bus.out_ready = r;
    flush         = f;
    for (int i = 0; i < MAX_MOP_CNT; i++) begin
      bundle[i] = rnd_mop();
      bus.in_mops[(MAX_MOP_CNT-1-i)*MOP_W +: MOP_W] = bundle[i];
    end
    @(posedge clk);
    if (f) begin
      q.delete();
      m_err = 1'b0;
    end else begin
      acc = v && (q.size() <= MOPQ_DEPTH - MAX_MOP_CNT);
      if (r && q.size() > 0) d = q.pop_front();
      m_err = acc && (c > MAX_MOP_CNT);
      if (acc && c <= MAX_MOP_CNT)
        for (int i = 0; i < c; i++) q.push_back('{bundle[i], logic'(i == c - 1)});
    end
    #1;
  endtask

  task automatic test_reset();
    bus.in_valid = 1'b0; bus.in_cnt = '0; bus.in_mops = '0; bus.out_ready = 1'b0;
    #12;
    checks++; if (bus.in_ready !== 1'b0) begin errors++; $display("FAIL reset_in_ready got %b want 0", bus.in_ready); end
    checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got %b want 0", bus.out_valid); end
    checks++; if (occupancy !== '0) begin errors++; $display("FAIL reset_occ got %0d want 0", occupancy); end
    checks++; if (err_cnt !== 1'b0) begin errors++; $display("FAIL reset_err got %b want 0", err_cnt); end
    checks++; if (bus.out_mop !== '0 || bus.out_last !== 1'b0) begin errors++; $display("FAIL reset_out_mop got %h/%b want 0/0", bus.out_mop, bus.out_last); end
    @(negedge clk); reset_n = 1'b1; #1;
    checks++; if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL post_reset_in_ready got %b want 1", bus.in_ready); end
  endtask

  task automatic test_basic();
    logic [MOP_W-1:0] a[4];
    cycle(1, 4, 1, 0);
    for (int i = 0; i < 4; i++) a[i] = bundle[i];
    checks++; if (occupancy !== 5'd4 || bus.out_mop !== a[0] || bus.out_last !== 1'b0) begin
      errors++; $display("FAIL basic_first got occ=%0d mop=%h last=%b want 4/%h/0", occupancy, bus.out_mop, bus.out_last, a[0]); end
    for (int k = 1; k <= 4; k++) begin
      cycle(0, 0, 1, 0);
      checks++; if (occupancy !== OCC_W'(4 - k)) begin errors++; $display("FAIL basic_occ%0d got %0d want %0d", k, occupancy, 4 - k); end
      if (k < 4) begin
        checks++; if (bus.out_mop !== a[k] || bus.out_last !== logic'(k == 3)) begin
          errors++; $display("FAIL basic_pop%0d got %h/%b want %h/%b", k, bus.out_mop, bus.out_last, a[k], k == 3); end
      end else begin
        checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL basic_empty got out_valid=%b want 0", bus.out_valid); end
      end
    end
  endtask

  task automatic test_full();
    logic [MOP_W-1:0] first;
    cycle(1, 6, 0, 0);
    first = bundle[0];
    checks++; if (occupancy !== 5'd6 || bus.in_ready !== 1'b1) begin errors++; $display("FAIL full_one got occ=%0d rdy=%b want 6/1", occupancy, bus.in_ready); end
    cycle(1, 6, 0, 0);
    checks++; if (occupancy !== 5'd12 || bus.in_ready !== 1'b0) begin errors++; $display("FAIL full_two got occ=%0d rdy=%b want 12/0", occupancy, bus.in_ready); end
    cycle(1, 6, 0, 0);
    checks++; if (occupancy !== 5'd12 || bus.out_mop !== first || bus.out_last !== 1'b0) begin
      errors++; $display("FAIL full_hold got occ=%0d mop=%h want 12/%h", occupancy, bus.out_mop, first); end
    cycle(0, 0, 1, 1);
    checks++; if (occupancy !== '0 || bus.out_valid !== 1'b0) begin errors++; $display("FAIL full_flush got occ=%0d vld=%b want 0/0", occupancy, bus.out_valid); end
  endtask

  task automatic test_wrap();
    logic [MOP_W-1:0] w[5];
    cycle(1, 6, 0, 0);
    cycle(1, 6, 0, 0);
    for (int k = 0; k < 10; k++) cycle(0, 0, 1, 0);
    cycle(1, 2, 0, 0);
    cycle(1, 5, 0, 0);
    for (int i = 0; i < 5; i++) w[i] = bundle[i];
    checks++; if (occupancy !== 5'd9) begin errors++; $display("FAIL wrap_occ got %0d want 9", occupancy); end
    for (int k = 0; k < 9; k++) begin
      if (k >= 4) begin
        checks++; if (bus.out_mop !== w[k-4] || bus.out_last !== logic'(k == 8)) begin
          errors++; $display("FAIL wrap_pop%0d got %h/%b want %h/%b", k, bus.out_mop, bus.out_last, w[k-4], k == 8); end
      end else begin
        checks++; if (bus.out_mop !== q[0].mop || bus.out_last !== q[0].last) begin
          errors++; $display("FAIL wrap_old%0d got %h/%b want %h/%b", k, bus.out_mop, bus.out_last, q[0].mop, q[0].last); end
      end
      cycle(0, 0, 1, 0);
    end
    checks++; if (occupancy !== '0) begin errors++; $display("FAIL wrap_drain got %0d want 0", occupancy); end
  endtask

  task automatic test_flush();
    cycle(1, 6, 0, 0);
    cycle(1, 1, 0, 0);
    checks++; if (occupancy !== 5'd7) begin errors++; $display("FAIL flush_pre got %0d want 7", occupancy); end
    cycle(1, 3, 1, 1);
    checks++; if (bus.in_ready !== 1'b0) begin errors++; $display("FAIL flush_in_ready got %b want 0", bus.in_ready); end
    checks++; if (occupancy !== '0 || bus.out_valid !== 1'b0) begin errors++; $display("FAIL flush_clear got occ=%0d vld=%b want 0/0", occupancy, bus.out_valid); end
    cycle(1, 2, 0, 0);
    checks++; if (occupancy !== 5'd2 || bus.out_mop !== bundle[0] || bus.in_ready !== 1'b1) begin
      errors++; $display("FAIL flush_refill got occ=%0d mop=%h rdy=%b want 2/%h/1", occupancy, bus.out_mop, bus.in_ready, bundle[0]); end
    cycle(0, 0, 1, 1);
  endtask

  task automatic test_err();
    cycle(1, 2, 0, 0);
    cycle(1, 0, 0, 0);
    checks++; if (occupancy !== 5'd2 || err_cnt !== 1'b0) begin errors++; $display("FAIL err_nop got occ=%0d err=%b want 2/0", occupancy, err_cnt); end
    cycle(1, 7, 0, 0);
    checks++; if (occupancy !== 5'd2 || err_cnt !== 1'b1) begin errors++; $display("FAIL err_cnt7 got occ=%0d err=%b want 2/1", occupancy, err_cnt); end
    cycle(0, 0, 0, 0);
    checks++; if (err_cnt !== 1'b0 || occupancy !== 5'd2) begin errors++; $display("FAIL err_pulse got err=%b occ=%0d want 0/2", err_cnt, occupancy); end
    cycle(0, 0, 0, 1);
  endtask

  task automatic test_async_reset();
    cycle(1, 6, 0, 0);
    cycle(1, 3, 0, 0);
    checks++; if (occupancy !== 5'd9) begin errors++; $display("FAIL arst_pre got %0d want 9", occupancy); end
    @(negedge clk);
    bus.in_valid = 1'b0;
    #2 reset_n = 1'b0;
    #1;
    q.delete(); m_err = 1'b0;
    checks++; if (bus.out_valid !== 1'b0 || occupancy !== '0 || bus.in_ready !== 1'b0 || bus.out_mop !== '0) begin
      errors++; $display("FAIL arst_now got vld=%b occ=%0d rdy=%b mop=%h want 0/0/0/0", bus.out_valid, occupancy, bus.in_ready, bus.out_mop); end
    #4 reset_n = 1'b1;
    #1;
    checks++; if (bus.in_ready !== 1'b1 || occupancy !== '0) begin errors++; $display("FAIL arst_release got rdy=%b occ=%0d want 1/0", bus.in_ready, occupancy); end
  endtask

  task automatic test_random();
    logic exp_rdy;
    for (int n = 0; n < 400; n++) begin
      cycle(logic'($urandom_range(0, 3) != 0), $urandom_range(0, 7),
            logic'($urandom_range(0, 2) != 0), logic'($urandom_range(0, 39) == 0));
      exp_rdy = !flush && (q.size() <= MOPQ_DEPTH - MAX_MOP_CNT);
      checks++; if (occupancy !== OCC_W'(q.size()) || bus.out_valid !== logic'(q.size() != 0)) begin
        errors++; $display("FAIL rnd_occ n=%0d got occ=%0d vld=%b want %0d", n, occupancy, bus.out_valid, q.size()); end
      checks++; if (err_cnt !== m_err || bus.in_ready !== exp_rdy) begin
        errors++; $display("FAIL rnd_ctl n=%0d got err=%b rdy=%b want %b/%b", n, err_cnt, bus.in_ready, m_err, exp_rdy); end
      if (q.size() != 0) begin
        checks++; if (bus.out_mop !== q[0].mop || bus.out_last !== q[0].last) begin
          errors++; $display("FAIL rnd_head n=%0d got %h/%b want %h/%b", n, bus.out_mop, bus.out_last, q[0].mop, q[0].last); end
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_full();
    test_wrap();
    test_flush();
    test_err();
    test_async_reset();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog simulation did not finish, errors=%0d", errors);
    $fatal(1, "watchdog");
  end

endmodule
